inst_fetch: RTL and testbench

Instruction fetch unit for the MyRISC core: the initiator side of the instruction-memory interface. It owns the program counter, drives `InstAddress` into the combinational instruction ROM and samples the returned word the same cycle. It advances sequentially or by absolute/relative branch, holds on stall, and stops on the all-ones halt word. A run is started by `Start`, and completion is reported on `Done` to the test harness.

---
 rtl/inst_fetch.sv | 102 ++++++++++
 tb/tb_inst_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit for the MyRISC core.
// Owns the program counter, drives it to a combinational instruction ROM,
// and decides the next PC from the returned word in the same cycle.
// Runs are started by Start and end when the all-ones halt word is fetched.
module inst_fetch #(
  parameter int A  = 10,
  parameter int W  = 10,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [A-1:0]  Target,
  input  logic [W-1:0]  InstIn,
  output logic [A-1:0]  InstAddress,
  output logic          Valid,
  output logic          Done,
  output logic [CW-1:0] RetCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt_word;

  // Retired-instruction counter sticks at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CW'(1);
  endfunction

  assign halt_word = &InstIn;

  // Next-state, next-PC and counter decode; restart beats stall beats halt beats branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Start) begin
          pc_d  = StartAddr;
          cnt_d = '0;
        end else if (!Stall) begin
          cnt_d = sat_inc(cnt_q);
          if (halt_word) begin
            // PC stays on the halt address so it remains visible while Done.
            state_d = HALT;
          end else if (BranchEn) begin
            // Two's-complement offset add wraps naturally at A bits.
            pc_d = BranchRel ? (pc_q + Target) : Target;
          end else begin
            pc_d = pc_q + A'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, PC and counter registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstAddress = pc_q;
  assign Valid       = (state_q == RUN);
  assign Done        = (state_q == HALT);
  assign RetCount    = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset, restart and saturation.
module tb_inst_fetch;

  localparam int A  = 10;
  localparam int W  = 10;
  localparam int CW = 16;

  logic          Clk;
  logic          Reset_n;
  logic          Start;
  logic [A-1:0]  StartAddr;
  logic          Stall;
  logic          BranchEn;
  logic          BranchRel;
  logic [A-1:0]  Target;
  logic [W-1:0]  InstIn;
  logic [A-1:0]  InstAddress;
  logic          Valid;
  logic          Done;
  logic [CW-1:0] RetCount;

  int n_vec;
  int n_fail;

  inst_fetch #(.A(A), .W(W), .CW(CW)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Stall      (Stall),
    .BranchEn   (BranchEn),
    .BranchRel  (BranchRel),
    .Target     (Target),
    .InstIn     (InstIn),
    .InstAddress(InstAddress),
    .Valid      (Valid),
    .Done       (Done),
    .RetCount   (RetCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          start;
    logic [A-1:0]  saddr;
    logic          stall;
    logic          br;
    logic          rel;
    logic [A-1:0]  tgt;
    logic [W-1:0]  inst;
    logic [A-1:0]  e_addr;
    logic          e_valid;
    logic          e_done;
    logic [CW-1:0] e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [A-1:0] addr, input logic vld,
                          input logic dn, input logic [CW-1:0] cnt);
    chk({nm, ".addr"},  32'(InstAddress), 32'(addr));
    chk({nm, ".valid"}, 32'(Valid),       32'(vld));
    chk({nm, ".done"},  32'(Done),        32'(dn));
    chk({nm, ".cnt"},   32'(RetCount),    32'(cnt));
  endtask

  // Drive one cycle of inputs between edges, then let one rising edge pass.
  task automatic drive(input logic st, input logic [A-1:0] sa, input logic stl,
                       input logic br, input logic rel, input logic [A-1:0] tg,
                       input logic [W-1:0] ins);
    @(negedge Clk);
    Start     = st;
    StartAddr = sa;
    Stall     = stl;
    BranchEn  = br;
    BranchRel = rel;
    Target    = tg;
    InstIn    = ins;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    //            st sa       stl br rel tgt       inst      addr     v  d  cnt
    vecs[0]  = '{1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 10'd5,   10'h000, 10'd0,   1'b0, 1'b0, 16'd0}; // IDLE ignores
    vecs[1]  = '{1'b1, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h000, 10'd0,   1'b1, 1'b0, 16'd0}; // start at 0
    vecs[2]  = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h001, 10'd1,   1'b1, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h002, 10'd2,   1'b1, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h003, 10'd3,   1'b1, 1'b0, 16'd3};
    vecs[5]  = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h004, 10'd4,   1'b1, 1'b0, 16'd4};
    vecs[6]  = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h3FF, 10'd4,   1'b0, 1'b1, 16'd5}; // halt at 4
    vecs[7]  = '{1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 10'd9,   10'h3FF, 10'd4,   1'b0, 1'b1, 16'd5}; // HALT frozen
    vecs[8]  = '{1'b1, 10'd3,   1'b0, 1'b0, 1'b0, 10'd0,   10'h3FF, 10'd3,   1'b1, 1'b0, 16'd0}; // restart from HALT
    vecs[9]  = '{1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 10'd10,  10'h000, 10'd10,  1'b1, 1'b0, 16'd1}; // abs branch
    vecs[10] = '{1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 10'h3FE, 10'h000, 10'd8,   1'b1, 1'b0, 16'd2}; // rel -2
    vecs[11] = '{1'b1, 10'd2,   1'b0, 1'b0, 1'b0, 10'd0,   10'h000, 10'd2,   1'b1, 1'b0, 16'd0}; // restart in RUN
    vecs[12] = '{1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 10'h3FD, 10'h000, 10'd1023,1'b1, 1'b0, 16'd1}; // rel -3 wraps
    vecs[13] = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h000, 10'd0,   1'b1, 1'b0, 16'd2}; // 1023+1 -> 0
    vecs[14] = '{1'b1, 10'd5,   1'b0, 1'b0, 1'b0, 10'd0,   10'h000, 10'd5,   1'b1, 1'b0, 16'd0};
    vecs[15] = '{1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 10'd0,   10'h000, 10'd5,   1'b1, 1'b0, 16'd0}; // stall x3
    vecs[16] = '{1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 10'd30,  10'h000, 10'd5,   1'b1, 1'b0, 16'd0};
    vecs[17] = '{1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 10'd0,   10'h000, 10'd5,   1'b1, 1'b0, 16'd0};
    vecs[18] = '{1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 10'd0,   10'h3FF, 10'd5,   1'b1, 1'b0, 16'd0}; // halt under stall
    vecs[19] = '{1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 10'd20,  10'h3FF, 10'd5,   1'b0, 1'b1, 16'd1}; // halt beats branch
    vecs[20] = '{1'b1, 10'd1023,1'b0, 1'b0, 1'b0, 10'd0,   10'h3FF, 10'd1023,1'b1, 1'b0, 16'd0};
    vecs[21] = '{1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   10'h000, 10'd0,   1'b1, 1'b0, 16'd1}; // wrap from 1023
    vecs[22] = '{1'b1, 10'd7,   1'b0, 1'b0, 1'b0, 10'd0,   10'h3FF, 10'd7,   1'b1, 1'b0, 16'd0}; // start beats halt
    vecs[23] = '{1'b1, 10'd9,   1'b1, 1'b0, 1'b0, 10'd0,   10'h000, 10'd9,   1'b1, 1'b0, 16'd0}; // start beats stall

    Reset_n   = 1'b0;
    Start     = 1'b0;
    StartAddr = '0;
    Stall     = 1'b0;
    BranchEn  = 1'b0;
    BranchRel = 1'b0;
    Target    = '0;
    InstIn    = '0;

    repeat (2) @(posedge Clk);
    #1;
    chk_outs("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].saddr, vecs[i].stall, vecs[i].br, vecs[i].rel,
            vecs[i].tgt, vecs[i].inst);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_valid,
               vecs[i].e_done, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-run at PC=6 with a nonzero count.
    drive(1'b1, 10'd4, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    chk_outs("prerst", 10'd6, 1'b1, 1'b0, 16'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_outs("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    chk_outs("idle_after_rst", 10'd0, 1'b0, 1'b0, 16'd0);

    // Halt at address 2, then restart at 2 from HALT.
    drive(1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h3FF);
    chk_outs("halt2", 10'd2, 1'b0, 1'b1, 16'd1);
    drive(1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'h3FF);
    chk_outs("restart2", 10'd2, 1'b1, 1'b0, 16'd0);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    chk_outs("resume3", 10'd3, 1'b1, 1'b0, 16'd1);

    // Counter saturation: 65540 retires from PC 0 leaves PC at 65540 mod 1024 = 4.
    drive(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'h000);
    @(negedge Clk);
    Start = 1'b0;
    repeat (65540) @(posedge Clk);
    #1;
    chk_outs("saturate", 10'd4, 1'b1, 1'b0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
